// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings, pattern constants and step-period helper for the
// LED sequencer.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ROT_LEFT  = 2'd0,
    ROT_RIGHT = 2'd1,
    BOUNCE    = 2'd2,
    BLINK     = 2'd3
  } mode_e;

  localparam logic [3:0] PATTERN_RESET = 4'b0001;
  localparam logic [3:0] PATTERN_BLINK = 4'b1111;

  // Base ticks per pattern step: 32/16/8/4 for speed 0..3.
  function automatic logic [5:0] step_period(input logic [1:0] speed);
    step_period = 6'd32 >> speed;
  endfunction

  function automatic logic [3:0] mode_reload(input mode_e mode);
    mode_reload = (mode == BLINK) ? PATTERN_BLINK : PATTERN_RESET;
  endfunction

endpackage

// File: rtl/led_sequencer_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchroniser, tick-gated debounce and a one-clock
// press pulse on an accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Synchronise every clock; debounce only on base ticks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_level     <= 1'b0;
      r_cnt       <= '0;
      r_press     <= 1'b0;
    end else begin
      r_sync_meta <= i_btn;
      r_sync      <= r_sync_meta;
      r_press     <= 1'b0;
      if (i_tick) begin
        if (r_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_level <= r_sync;
          r_cnt   <= '0;
          r_press <= r_sync;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_sequencer_ctrl_chk.sv
// Output-level invariants: moving modes show exactly one lit LED, blink shows
// all-on or all-off.
module led_sequencer_ctrl_chk (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic [3:0] i_leds,
  input logic [1:0] i_mode
);

  a_one_hot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_mode != 2'd3) |-> $onehot(i_leds));

  a_blink_uniform: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_mode == 2'd3) |-> ((i_leds == 4'b1111) || (i_leds == 4'b0000)));

endmodule

// File: rtl/led_sequencer_ctrl.sv
// LED sequencer top: base tick generator, two debounced buttons, step
// scheduler and the display-mode FSM driving the 4-LED pattern.
module led_sequencer_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV       = 8333,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       CLK_3p33MHZ,
  input  logic       RESET_N,
  input  logic       BTN_MODE,
  input  logic       BTN_SPEED,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic [1:0] MODE,
  output logic [1:0] SPEED
);

  localparam logic [21:0] TICK_LAST = 22'(TICK_DIV - 1);

  logic [21:0] r_tick_cnt;
  logic        r_tick;
  logic [4:0]  r_step_cnt;
  logic [3:0]  r_pattern;
  mode_e       r_mode;
  logic [1:0]  r_speed;
  logic        r_dir_left;

  logic        w_mode_press;
  logic        w_speed_press;
  logic        w_step_last;
  mode_e       w_mode_next;
  logic [3:0]  w_step_pattern;
  logic        w_bounce_flip;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_mode (
    .i_clk   (CLK_3p33MHZ),
    .i_rst_n (RESET_N),
    .i_tick  (r_tick),
    .i_btn   (BTN_MODE),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_speed (
    .i_clk   (CLK_3p33MHZ),
    .i_rst_n (RESET_N),
    .i_tick  (r_tick),
    .i_btn   (BTN_SPEED),
    .o_press (w_speed_press)
  );

  // Base tick: one registered pulse every TICK_DIV clocks.
  always_ff @(posedge CLK_3p33MHZ) begin
    if (!RESET_N) begin
      r_tick_cnt <= 22'd0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= 22'd0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 22'd1;
      r_tick     <= 1'b0;
    end
  end

  assign w_step_last = ({1'b0, r_step_cnt} == (step_period(r_speed) - 6'd1));
  assign w_mode_next = mode_e'(r_mode + 2'd1);

  // Next pattern for a scheduled step in the current mode.
  always_comb begin
    w_step_pattern = r_pattern;
    w_bounce_flip  = 1'b0;
    case (r_mode)
      ROT_LEFT:  w_step_pattern = {r_pattern[2:0], r_pattern[3]};
      ROT_RIGHT: w_step_pattern = {r_pattern[0], r_pattern[3:1]};
      BOUNCE: begin
        if (r_dir_left) begin
          if (r_pattern == 4'b1000) begin
            w_bounce_flip  = 1'b1;
            w_step_pattern = 4'b0100;
          end else begin
            w_step_pattern = {r_pattern[2:0], 1'b0};
          end
        end else begin
          if (r_pattern == 4'b0001) begin
            w_bounce_flip  = 1'b1;
            w_step_pattern = 4'b0010;
          end else begin
            w_step_pattern = {1'b0, r_pattern[3:1]};
          end
        end
      end
      BLINK:     w_step_pattern = ~r_pattern;
      default:   w_step_pattern = r_pattern;
    endcase
  end

  // Mode/speed FSM; a button press always wins over a step due this cycle.
  always_ff @(posedge CLK_3p33MHZ) begin
    if (!RESET_N) begin
      r_step_cnt <= 5'd0;
      r_pattern  <= PATTERN_RESET;
      r_mode     <= ROT_LEFT;
      r_speed    <= 2'd0;
      r_dir_left <= 1'b1;
    end else if (w_mode_press || w_speed_press) begin
      r_step_cnt <= 5'd0;
      if (w_mode_press) begin
        r_mode     <= w_mode_next;
        r_pattern  <= mode_reload(w_mode_next);
        r_dir_left <= 1'b1;
      end else begin
        r_mode <= r_mode;
      end
      if (w_speed_press) begin
        r_speed <= r_speed + 2'd1;
      end else begin
        r_speed <= r_speed;
      end
    end else if (r_tick) begin
      if (w_step_last) begin
        r_step_cnt <= 5'd0;
        r_pattern  <= w_step_pattern;
        if (w_bounce_flip) begin
          r_dir_left <= ~r_dir_left;
        end else begin
          r_dir_left <= r_dir_left;
        end
      end else begin
        r_step_cnt <= r_step_cnt + 5'd1;
      end
    end else begin
      r_step_cnt <= r_step_cnt;
    end
  end

  assign LED2  = r_pattern[3];
  assign LED3  = r_pattern[2];
  assign LED4  = r_pattern[1];
  assign LED5  = r_pattern[0];
  assign MODE  = r_mode;
  assign SPEED = r_speed;

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Scoreboard bench for led_sequencer_ctrl: a rule-level model predicts every
// output change and its clock edge; a monitor compares each observed change.
module tb_led_sequencer_ctrl;

  localparam int TD = 4;
  localparam int DT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_m = 1'b0;
  logic btn_s = 1'b0;
  logic led2, led3, led4, led5;
  logic [1:0] mode_o, speed_o;

  always #5 clk = ~clk;

  led_sequencer_ctrl #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DT)) dut (
    .CLK_3p33MHZ (clk),
    .RESET_N     (rst_n),
    .BTN_MODE    (btn_m),
    .BTN_SPEED   (btn_s),
    .LED2        (led2),
    .LED3        (led3),
    .LED4        (led4),
    .LED5        (led5),
    .MODE        (mode_o),
    .SPEED       (speed_o)
  );

  led_sequencer_ctrl_chk u_chk (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_leds  ({led2, led3, led4, led5}),
    .i_mode  (mode_o)
  );

  typedef struct packed {
    int         cyc;
    logic [3:0] leds;
    logic [1:0] mode;
    logic [1:0] speed;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state, expressed in terms of the rules, not registers.
  int e = 0;
  int m_mode = 0;
  int m_speed = 0;
  int m_n = 0;
  int m_t = 0;
  bit s1[2], s2[2], acc[2], pend[2], b[2];
  int dcnt[2];
  bit mp, sp, tk;
  logic [3:0] p;
  logic [3:0] prev_p = 4'b0001;
  int prev_mode = 0;
  int prev_speed = 0;

  // Pattern after n steps since the last mode entry.
  function automatic logic [3:0] model_pattern(input int mode, input int n);
    logic [3:0] one;
    one = 4'b0001;
    case (mode)
      0: model_pattern = one << (n % 4);
      1: model_pattern = one << ((4 - (n % 4)) % 4);
      2: begin
        case (n % 6)
          0: model_pattern = 4'b0001;
          1: model_pattern = 4'b0010;
          2: model_pattern = 4'b0100;
          3: model_pattern = 4'b1000;
          4: model_pattern = 4'b0100;
          default: model_pattern = 4'b0010;
        endcase
      end
      default: model_pattern = ((n % 2) == 0) ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    b[0] = btn_m;
    b[1] = btn_s;
    if (!rst_n) begin
      e = 0; m_mode = 0; m_speed = 0; m_n = 0; m_t = 0;
      for (int i = 0; i < 2; i++) begin
        s1[i] = 1'b0; s2[i] = 1'b0; acc[i] = 1'b0; pend[i] = 1'b0; dcnt[i] = 0;
      end
    end else begin
      e = e + 1;
      tk = (e > TD) && (((e - 1) % TD) == 0);
      mp = pend[0];
      sp = pend[1];
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      if (tk) begin
        for (int i = 0; i < 2; i++) begin
          if (s2[i] == acc[i]) begin
            dcnt[i] = 0;
          end else begin
            dcnt[i] = dcnt[i] + 1;
            if (dcnt[i] == DT) begin
              acc[i] = s2[i];
              dcnt[i] = 0;
              pend[i] = s2[i];
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        s2[i] = s1[i];
        s1[i] = b[i];
      end
      if (mp || sp) begin
        m_t = 0;
        if (mp) begin
          m_mode = (m_mode + 1) % 4;
          m_n = 0;
        end
        if (sp) m_speed = (m_speed + 1) % 4;
      end else if (tk) begin
        m_t = m_t + 1;
        if (m_t == (32 >> m_speed)) begin
          m_t = 0;
          m_n = m_n + 1;
        end
      end
    end
    p = model_pattern(m_mode, m_n);
    if (p != prev_p || m_mode != prev_mode || m_speed != prev_speed) begin
      q.push_back({cyc, p, 2'(m_mode), 2'(m_speed)});
      prev_p = p;
      prev_mode = m_mode;
      prev_speed = m_speed;
    end
  end

  bit mon_en = 1'b0;
  logic [3:0] seen_p = 4'b0001;
  logic [1:0] seen_m = 2'd0;
  logic [1:0] seen_s = 2'd0;
  exp_t x;

  always @(negedge clk) begin
    if (mon_en) begin
      if ({led2, led3, led4, led5} != seen_p || mode_o != seen_m || speed_o != seen_s) begin
        seen_p = {led2, led3, led4, led5};
        seen_m = mode_o;
        seen_s = speed_o;
        total = total + 1;
        if (q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_change cyc=%0d got leds=%b mode=%0d speed=%0d required no change",
                   cyc, seen_p, seen_m, seen_s);
        end else begin
          x = q.pop_front();
          if (x.cyc != cyc || x.leds != seen_p || x.mode != seen_m || x.speed != seen_s) begin
            bad = bad + 1;
            $display("FAIL output_change got cyc=%0d leds=%b mode=%0d speed=%0d required cyc=%0d leds=%b mode=%0d speed=%0d",
                     cyc, seen_p, seen_m, seen_s, x.cyc, x.leds, x.mode, x.speed);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which, input int hold);
    @(negedge clk);
    if (which != 1) btn_m = 1'b1;
    if (which != 0) btn_s = 1'b1;
    repeat (hold) @(negedge clk);
    btn_m = 1'b0;
    btn_s = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(5);
    total = total + 1;
    if ({led2, led3, led4, led5} != 4'b0001 || mode_o != 2'd0 || speed_o != 2'd0) begin
      bad = bad + 1;
      $display("FAIL reset_state got leds=%b mode=%0d speed=%0d required leds=0001 mode=0 speed=0",
               {led2, led3, led4, led5}, mode_o, speed_o);
    end
    mon_en = 1'b1;
    rst_n = 1'b1;
    idle(600);

    // Into BOUNCE, then BLINK, then back to ROT_LEFT.
    press(0, 40); idle(200);
    press(0, 40); idle(1000);
    press(0, 40); idle(400);
    press(0, 40); idle(300);

    // Speed stepping through all four settings.
    for (int i = 0; i < 3; i++) begin
      press(1, $urandom_range(20, 60));
      idle($urandom_range(100, 200));
    end
    idle(300);
    press(1, 40); idle(400);

    // Bouncing mode button, then a clean hold.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); btn_m = 1'b1;
      idle(3);
      btn_m = 1'b0;
      idle(5);
    end
    press(0, 60); idle(400);

    // Simultaneous press, then a reset during a second debounce.
    press(2, 40); idle(300);
    @(negedge clk); btn_m = 1'b1; btn_s = 1'b1;
    idle(4);
    rst_n = 1'b0; btn_m = 1'b0; btn_s = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(400);

    // Randomised presses of either or both buttons.
    for (int i = 0; i < 14; i++) begin
      press($urandom_range(0, 2), $urandom_range(3, 60));
      idle($urandom_range(10, 250));
    end
    idle(300);

    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_changes got %0d outstanding required 0", q.size());
    end
    total = total + 1;
    if ({led2, led3, led4, led5} != prev_p || mode_o != 2'(prev_mode) || speed_o != 2'(prev_speed)) begin
      bad = bad + 1;
      $display("FAIL final_state got leds=%b mode=%0d speed=%0d required leds=%b mode=%0d speed=%0d",
               {led2, led3, led4, led5}, mode_o, speed_o, prev_p, prev_mode, prev_speed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
